// File: rtl/pkg_soc_interconnect.sv
// Shared types and constants for the SoC TCDM interconnect.
package pkg_soc_interconnect;

    // One address-map rule: addresses in [start_addr, end_addr) go to slave idx.
    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_map_rule_t;

    // Read data returned for accesses that hit no rule.
    localparam logic [31:0] ERR_RDATA = 32'hBADACCE5;

endpackage

// File: rtl/soc_tcdm_rr_arbiter.sv
// Round-robin arbiter with a highest-priority pointer that moves past the winner on a handshake.
module soc_tcdm_rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index
);

    logic [IW-1:0] ptr_q;
    logic          any_req;

    // Lowest requester at or above the pointer wins, else wrap to the lowest requester overall.
    always_comb begin
        index   = '0;
        any_req = 1'b0;
        grant   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                index   = IW'(i);
                any_req = 1'b1;
            end
        end
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i] && (i >= int'(ptr_q))) index = IW'(i);
        end
        for (int i = 0; i < int'(N); i++) begin
            grant[i] = any_req && (index == IW'(i));
        end
    end

    // Pointer becomes winner+1 (mod N) on a handshake and holds otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (index == IW'(N - 1)) ? '0 : index + 1'b1;
        end
    end

endmodule

// File: rtl/soc_tcdm_rr_xbar.sv
// TCDM crossbar: per-master address decode, per-slave round-robin arbitration,
// single-cycle response routing and an error responder for unmapped addresses.
module soc_tcdm_rr_xbar
    import pkg_soc_interconnect::*;
#(
    parameter int unsigned NR_MASTERS = 4,
    parameter int unsigned NR_SLAVES  = 3,
    parameter int unsigned NR_RULES   = 3,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  addr_map_rule_t [NR_RULES-1:0]             addr_map_i,
    input  logic [NR_MASTERS-1:0]                     m_req_i,
    input  logic [NR_MASTERS-1:0][ADDR_WIDTH-1:0]     m_add_i,
    input  logic [NR_MASTERS-1:0]                     m_wen_i,
    input  logic [NR_MASTERS-1:0][DATA_WIDTH-1:0]     m_wdata_i,
    input  logic [NR_MASTERS-1:0][DATA_WIDTH/8-1:0]   m_be_i,
    output logic [NR_MASTERS-1:0]                     m_gnt_o,
    output logic [NR_MASTERS-1:0]                     m_r_valid_o,
    output logic [NR_MASTERS-1:0][DATA_WIDTH-1:0]     m_r_rdata_o,
    output logic [NR_MASTERS-1:0]                     m_r_opc_o,
    output logic [NR_SLAVES-1:0]                      s_req_o,
    output logic [NR_SLAVES-1:0][ADDR_WIDTH-1:0]      s_add_o,
    output logic [NR_SLAVES-1:0]                      s_wen_o,
    output logic [NR_SLAVES-1:0][DATA_WIDTH-1:0]      s_wdata_o,
    output logic [NR_SLAVES-1:0][DATA_WIDTH/8-1:0]    s_be_o,
    input  logic [NR_SLAVES-1:0]                      s_gnt_i,
    input  logic [NR_SLAVES-1:0]                      s_r_valid_i,
    input  logic [NR_SLAVES-1:0][DATA_WIDTH-1:0]      s_r_rdata_i,
    input  logic [NR_SLAVES-1:0]                      s_r_opc_i
);

    localparam int unsigned MIW = (NR_MASTERS > 1) ? $clog2(NR_MASTERS) : 1;

    logic [NR_MASTERS-1:0][NR_SLAVES-1:0] m_sel;
    logic [NR_MASTERS-1:0]                m_unmapped;
    logic                                 dec_hit;
    logic [31:0]                          dec_tgt;

    logic [NR_SLAVES-1:0][NR_MASTERS-1:0] arb_req;
    logic [NR_SLAVES-1:0][NR_MASTERS-1:0] arb_gnt;
    logic [NR_SLAVES-1:0][MIW-1:0]        arb_idx;
    logic [NR_SLAVES-1:0]                 advance;

    logic [NR_SLAVES-1:0]                 pend_p1;
    logic [NR_SLAVES-1:0][MIW-1:0]        widx_p1;
    logic [NR_MASTERS-1:0]                err_p1;

    // Address decode: lowest-numbered matching rule with an in-range idx selects the slave.
    always_comb begin
        m_sel      = '0;
        m_unmapped = '0;
        dec_hit    = 1'b0;
        dec_tgt    = '0;
        for (int i = 0; i < int'(NR_MASTERS); i++) begin
            dec_hit = 1'b0;
            dec_tgt = '0;
            for (int r = int'(NR_RULES) - 1; r >= 0; r--) begin
                if ((m_add_i[i] >= ADDR_WIDTH'(addr_map_i[r].start_addr)) &&
                    (m_add_i[i] <  ADDR_WIDTH'(addr_map_i[r].end_addr))) begin
                    dec_hit = 1'b1;
                    dec_tgt = addr_map_i[r].idx;
                end
            end
            for (int j = 0; j < int'(NR_SLAVES); j++) begin
                m_sel[i][j] = dec_hit && (dec_tgt == 32'(j));
            end
            m_unmapped[i] = ~|m_sel[i];
        end
    end

    // Transpose master requests into per-slave requester vectors.
    always_comb begin
        arb_req = '0;
        for (int j = 0; j < int'(NR_SLAVES); j++) begin
            for (int i = 0; i < int'(NR_MASTERS); i++) begin
                arb_req[j][i] = m_req_i[i] & m_sel[i][j];
            end
        end
    end

    assign advance = s_req_o & s_gnt_i;

    for (genvar j = 0; j < int'(NR_SLAVES); j++) begin : g_arb
        soc_tcdm_rr_arbiter #(
            .N  (NR_MASTERS),
            .IW (MIW)
        ) i_arb (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .req     (arb_req[j]),
            .advance (advance[j]),
            .grant   (arb_gnt[j]),
            .index   (arb_idx[j])
        );
    end

    // Drive each slave port with its winning master's request.
    always_comb begin
        s_req_o   = '0;
        s_add_o   = '0;
        s_wen_o   = '0;
        s_wdata_o = '0;
        s_be_o    = '0;
        for (int j = 0; j < int'(NR_SLAVES); j++) begin
            s_req_o[j] = |arb_req[j];
            for (int i = 0; i < int'(NR_MASTERS); i++) begin
                if (arb_gnt[j][i]) begin
                    s_add_o[j]   = m_add_i[i];
                    s_wen_o[j]   = m_wen_i[i];
                    s_wdata_o[j] = m_wdata_i[i];
                    s_be_o[j]    = m_be_i[i];
                end
            end
        end
    end

    // Grants: unmapped requests are accepted at once, mapped ones follow the slave grant.
    always_comb begin
        m_gnt_o = '0;
        if (rst_ni) begin
            m_gnt_o = m_req_i & m_unmapped;
            for (int j = 0; j < int'(NR_SLAVES); j++) begin
                for (int i = 0; i < int'(NR_MASTERS); i++) begin
                    if (arb_gnt[j][i] && s_gnt_i[j]) m_gnt_o[i] = 1'b1;
                end
            end
        end
    end

    // ---- stage p1: remember who owns each slave response and pending error responses ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_p1 <= '0;
            widx_p1 <= '0;
            err_p1  <= '0;
        end else begin
            err_p1 <= m_req_i & m_unmapped;
            for (int j = 0; j < int'(NR_SLAVES); j++) begin
                if (advance[j]) begin
                    pend_p1[j] <= 1'b1;
                    widx_p1[j] <= arb_idx[j];
                end
            end
        end
    end

    // Route slave responses and error responses back to their masters.
    always_comb begin
        m_r_valid_o = '0;
        m_r_rdata_o = '0;
        m_r_opc_o   = '0;
        for (int i = 0; i < int'(NR_MASTERS); i++) begin
            if (err_p1[i]) begin
                m_r_valid_o[i] = 1'b1;
                m_r_rdata_o[i] = DATA_WIDTH'(ERR_RDATA);
                m_r_opc_o[i]   = 1'b1;
            end
        end
        for (int j = 0; j < int'(NR_SLAVES); j++) begin
            for (int i = 0; i < int'(NR_MASTERS); i++) begin
                if (pend_p1[j] && s_r_valid_i[j] && (widx_p1[j] == MIW'(i))) begin
                    m_r_valid_o[i] = 1'b1;
                    m_r_rdata_o[i] = s_r_rdata_i[j];
                    m_r_opc_o[i]   = s_r_opc_i[j];
                end
            end
        end
    end

endmodule

// File: doc/soc_tcdm_rr_xbar.md
SOC_TCDM_RR_XBAR -- requirements
Module: soc_tcdm_rr_xbar

Interface
REQ-001 SHALL have parameter NR_MASTERS, default 4: number of TCDM master ports, range 1..16.
REQ-002 SHALL have parameter NR_SLAVES, default 3: number of contiguous TCDM slave ports, range 1..16.
REQ-003 SHALL have parameter NR_RULES, default 3: number of address-map rules.
REQ-004 SHALL have parameter ADDR_WIDTH, default 32: address width.
REQ-005 SHALL have parameter DATA_WIDTH, default 32: data width; byte-enable width is DATA_WIDTH/8.
REQ-006 SHALL have port clk_i, input, 1: the single clock.
REQ-007 SHALL have port rst_ni, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port addr_map_i, input, NR_RULES x addr_map_rule_t: the rule table (idx, start_addr, end_addr exclusive), static during operation.
REQ-009 SHALL have ports m_req_i, m_add_i, m_wen_i (1 = read), m_wdata_i and m_be_i, all inputs, each NR_MASTERS wide: master requests.
REQ-010 SHALL have ports m_gnt_o, m_r_valid_o, m_r_rdata_o and m_r_opc_o, all outputs, each NR_MASTERS wide: master grant and response.
REQ-011 SHALL have ports s_req_o, s_add_o, s_wen_o, s_wdata_o and s_be_o, all outputs, each NR_SLAVES wide: slave requests.
REQ-012 SHALL have ports s_gnt_i, s_r_valid_i, s_r_rdata_i and s_r_opc_i, all inputs, each NR_SLAVES wide: slave grant and response.

Function
REQ-013 Decode SHALL be combinational per master: the target is the idx of the lowest-numbered rule with start_addr <= add < end_addr; no match or idx >= NR_SLAVES means unmapped.
REQ-014 Each slave SHALL have an independent round-robin arbiter over the masters currently requesting it.
REQ-015 The arbiter pointer SHALL be the highest-priority index: after a handshake (s_req_o & s_gnt_i) the pointer SHALL become the granted index +1, modulo NR_MASTERS; with no handshake it SHALL hold.
REQ-016 s_req_o[j] SHALL be asserted whenever any master targets slave j, carrying the winning master's add/wen/wdata/be; m_gnt_o[i] SHALL equal (master i is the winner) & s_gnt_i[j].
REQ-017 On a handshake the block SHALL register the winning master index and a pending flag for slave j; the slave's r_valid SHALL arrive exactly one cycle after the grant, and the block SHALL route s_r_valid/rdata/opc to that master combinationally (0-cycle added latency).
REQ-018 An unmapped request SHALL be granted in the same cycle, with no arbitration, independently per master; one cycle later the block SHALL return m_r_valid_o=1, m_r_opc_o=1 and m_r_rdata_o=ERR_RDATA; writes SHALL have no side effect.
REQ-019 Back-to-back requests from one master SHALL be supported at one per cycle, including alternating between slaves and the error path; at most one response SHALL target a master per cycle by construction.
REQ-020 Masters targeting different slaves SHALL be granted in the same cycle without interference.
REQ-021 Non-winning masters SHALL see m_gnt_o=0 and MUST hold their request stable (TCDM rule); the block SHALL NOT buffer requests.
REQ-022 When s_gnt_i is low, the pointer and pending state SHALL be unchanged and s_req_o SHALL remain asserted.
REQ-023 m_r_valid_o SHALL be 0 in any cycle without a routed response; rdata/opc are don't-care then, but SHALL be driven to 0.

Reset
REQ-024 While rst_ni is low, all pointers, pending flags, registered master indices and error-response flags SHALL be 0.
REQ-025 During reset, m_gnt_o, m_r_valid_o, m_r_opc_o and m_r_rdata_o SHALL be 0; s_req_o SHALL follow requests combinationally, with the pointer at 0.
REQ-026 Responses in flight when reset asserts SHALL be dropped; a slave r_valid in the first cycle after release SHALL be ignored.

Structure
REQ-027 addr_map_rule_t and ERR_RDATA (32'hBADACCE5, zero-extended to DATA_WIDTH) SHALL live in pkg_soc_interconnect.
REQ-028 The per-slave arbiter SHALL be the sub-module soc_tcdm_rr_arbiter (parameter N, inputs req and advance, outputs onehot grant and index), instantiated NR_SLAVES times.

Verification
REQ-029 Test 1: with defaults, master 0 reads 0x1C000000 (rule idx 0) and slave 0 returns 0x12345678 with gnt high -> same-cycle m_gnt_o[0], next-cycle m_r_valid_o[0]=1 with 0x12345678 and opc 0.
REQ-030 Test 2: all 4 masters continuously request slave 1 with gnt=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3, each response routed to the correct master.
REQ-031 Test 3: master 2 writes unmapped address 0x00000000 -> immediate grant; next cycle r_valid=1, opc=1, rdata 0xBADACCE5; no s_req_o asserted.
REQ-032 Test 4: masters 0 and 1 hit slaves 0 and 1 and master 3 is unmapped, all in the same cycle -> three grants in one cycle and three responses the next.
REQ-033 Test 5: s_gnt_i[0] held low for 5 cycles with 2 requesters -> no grants and pointer frozen; on release, the master at the pointer wins first.
REQ-034 Test 6: assert rst_ni low in the cycle after a grant -> no m_r_valid_o; after release, pointers are 0 and the next contention is won by master 0.
